parity_unit: RTL

- Parametrised parity block for the UART path. It serves both directions.
- TX side: computes the frame parity bit from a parallel word and holds it for the serializer.
- RX side: accumulates parity over the serially sampled data bits, then checks the received parity bit. It reports the result with registered done and error pulses.
- Adds configurable width and four parity modes (even, odd, mark, space) to a single-mode TX-only generator.

---
 rtl/parity_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/parity_unit.sv
// ============================================================================
// Module      : parity_unit
// Description : UART parity generator (TX) and accumulating checker (RX),
//               with configurable data width and even/odd/mark/space modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  par_en,
  input  logic [1:0]            par_mode,
  input  logic                  tx_data_valid,
  input  logic                  tx_busy,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_par_bit,
  input  logic                  rx_start,
  input  logic                  rx_bit_valid,
  input  logic                  rx_bit,
  output logic                  rx_busy,
  output logic                  rx_par_done,
  output logic                  rx_par_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DATA_WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_acc;
  logic             w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             r_en;
  logic             w_en_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_rx_exp;
  logic             r_tx_par;

  // x is the XOR of the data bits; mark/space ignore it.
  function automatic logic par_fn(input logic [1:0] mode, input logic x);
    case (mode)
      2'b00:   par_fn = x;
      2'b01:   par_fn = ~x;
      2'b10:   par_fn = 1'b1;
      default: par_fn = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------- TX side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_par <= 1'b0;
    end else if (tx_data_valid && !tx_busy) begin
      r_tx_par <= par_en & par_fn(par_mode, ^tx_data);
    end
  end

  assign tx_par_bit = r_tx_par;

  // ---------------------------------------------------------------- RX side
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_rx_exp  = par_fn(r_mode, r_acc);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_en_nxt    = r_en;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    // A start from any state begins a fresh frame; any strobe alongside it
    // belongs to no data bit and is dropped.
    if (rx_start) begin
      w_state_nxt = S_DATA;
      w_acc_nxt   = 1'b0;
      w_cnt_nxt   = '0;
      w_mode_nxt  = par_mode;
      w_en_nxt    = par_en;
    end else begin
      case (r_state)
        S_DATA: begin
          if (rx_bit_valid) begin
            w_acc_nxt = r_acc ^ rx_bit;
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_LAST_CNT) begin
              if (r_en) begin
                w_state_nxt = S_PAR;
              end else begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
        S_PAR: begin
          if (rx_bit_valid) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = r_en & (rx_bit != w_rx_exp);
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign rx_busy     = (r_state == S_DATA) || (r_state == S_PAR);
  assign rx_par_done = r_done;
  assign rx_par_err  = r_err;

endmodule

`default_nettype wire
